ram_copy_dma: RTL and testbench
===============================

// Module: ram_copy_dma
//
// PURPOSE
// Bus initiator for the 32-bit byte-addressed BRAM port (en/wr/be/addr/data). Copies or fills
// a block of N words without the CPU, issuing one access per granted cycle. Sits beside the CPU
// as a second master behind the RAM arbiter; control comes from an IO register block.
//
// PARAMETERS
// ADDR_WIDTH  17  byte address width of the RAM port (17 = 128 kB)
// CNT_WIDTH   16  width of word-count register; max transfer 2^CNT_WIDTH-1 words
//
// PORTS
// clk        in   1           system clock; RAM is clocked on ~clk
// rst_n      in   1           asynchronous, active-low reset
// start      in   1           1-cycle pulse: latch parameters, begin transfer (ignored when busy)
// mode       in   1           0 = copy src->dst, 1 = fill dst with fill_data
// src_addr   in   ADDR_WIDTH  source byte address; bits [1:0] ignored (forced 00)
// dst_addr   in   ADDR_WIDTH  destination byte address; bits [1:0] ignored
// count      in   CNT_WIDTH   number of 32-bit words
// fill_data  in   32          pattern for fill mode
// abort      in   1           stop transfer after current cycle
// busy       out  1           high from cycle after start until back in IDLE
// done       out  1           1-cycle pulse on normal completion (not on abort)
// bus_req    out  1           request to arbiter; high in RD and WR states
// bus_gnt    in   1           arbiter grant, valid same cycle
// ram_en     out  1           RAM enable
// ram_wr     out  1           RAM write
// ram_be     out  1           byte enable; always 0 (word accesses only)
// ram_addr   out  ADDR_WIDTH  RAM byte address, bits [1:0] always 00
// ram_wdata  out  32          write data
// ram_rdata  in   32          read data, valid at next posedge after read cycle's posedge
//
// BEHAVIOUR
// - Reset: state IDLE; busy, done, bus_req, ram_en, ram_wr, ram_be = 0; ram_addr, ram_wdata,
//   internal src/dst/cnt/buf = 0. Reset mid-transfer abandons it; no done.
// - States: IDLE, RD, WR, FIN.
//   IDLE: start & count!=0 -> RD (copy) or WR (fill); start & count==0 -> FIN.
//   RD: access = en=1,wr=0,addr=src. On posedge with gnt=1: buf<=ram_rdata, src+=4 -> WR.
//   WR: en=1,wr=1,addr=dst,wdata=buf (copy) / fill_data latched at start (fill).
//       On posedge with gnt=1: dst+=4, cnt-=1; cnt==1 -> FIN; else RD (copy) / WR (fill).
//   FIN: done=1 for exactly this cycle, busy=0 here -> IDLE.
// - Read timing: RAM samples on negedge; data valid before the ending posedge of the RD cycle;
//   buf captured at that posedge. Copy = 2 granted cycles/word; fill = 1.
// - Grant: ram_en = (RD|WR) & bus_gnt; ram_wr = WR & bus_gnt. gnt=0 -> no RAM strobes, state,
//   addresses and count held; request stays asserted.
// - Addresses increment by 4 modulo 2^ADDR_WIDTH (wrap to 0, no error).
// - Overlapping src/dst: strict ascending word order, no hazard handling.
// - abort in RD/WR: current cycle's granted access completes; next state IDLE, no done.
//   abort in IDLE/FIN ignored. abort and last write same cycle: abort wins (no done).
// - start while busy ignored; parameters latched only on accepted start.
// - busy = state != IDLE & state != FIN.
//
// TESTING
// 1 copy: RAM[0x100..0x108]=A,B,C; src=0x100,dst=0x200,count=3,gnt=1 -> RAM[0x200..0x208]=
//   A,B,C; 6 access cycles; done pulse once in cycle 7 after start; busy low after.
// 2 fill: dst=0x40,count=4,fill=0xDEADBEEF -> 0x40..0x4C = DEADBEEF, 4 write cycles, done;
//   0x50 untouched.
// 3 count=0 -> done next cycle, ram_en never asserted, busy never asserted.
// 4 grant stall: copy count=2, drop gnt 3 cycles during WR -> ram_en=0 those cycles,
//   same addr/wdata on resume, correct result, done delayed by 3 cycles.
// 5 wrap: dst=2^ADDR_WIDTH-4, fill count=2 -> writes last word then address 0x0.
// 6 abort mid-copy of 8 words after 3rd write -> 3 words copied, rest unchanged, no done;
//   rst_n low mid-transfer -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ram_copy_dma.sv
// ============================================================================
// Module      : ram_copy_dma
// Description : Word-granular copy/fill bus initiator for the shared BRAM port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_copy_dma #(
  parameter int ADDR_WIDTH = 17,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [CNT_WIDTH-1:0]  count,
  input  logic [31:0]           fill_data,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  bus_req,
  input  logic                  bus_gnt,
  output logic                  ram_en,
  output logic                  ram_wr,
  output logic                  ram_be,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] c_word_step  = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] c_align_mask = ~ADDR_WIDTH'(3);
  localparam logic [CNT_WIDTH-1:0]  c_cnt_last   = CNT_WIDTH'(1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_mode;
  logic [31:0]           r_fill;
  logic [31:0]           r_buf;
  logic [ADDR_WIDTH-1:0] r_src;
  logic [ADDR_WIDTH-1:0] r_dst;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  w_rd;
  logic                  w_wr;

  assign w_rd = (r_state == S_RD);
  assign w_wr = (r_state == S_WR);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (count == '0) w_state_nxt = S_FIN;
          else             w_state_nxt = mode ? S_WR : S_RD;
        end
      end
      S_RD: begin
        if (abort)        w_state_nxt = S_IDLE;
        else if (bus_gnt) w_state_nxt = S_WR;
      end
      S_WR: begin
        // abort takes priority over the final write's completion, so no done
        if (abort)                    w_state_nxt = S_IDLE;
        else if (bus_gnt) begin
          if (r_cnt == c_cnt_last)    w_state_nxt = S_FIN;
          else                        w_state_nxt = r_mode ? S_WR : S_RD;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_fill  <= '0;
      r_buf   <= '0;
      r_src   <= '0;
      r_dst   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && start) begin
        r_mode <= mode;
        r_fill <= fill_data;
        r_src  <= src_addr & c_align_mask;
        r_dst  <= dst_addr & c_align_mask;
        r_cnt  <= count;
      end
      if (w_rd && bus_gnt) begin
        r_buf <= ram_rdata;
        r_src <= r_src + c_word_step;
      end
      if (w_wr && bus_gnt) begin
        r_dst <= r_dst + c_word_step;
        r_cnt <= r_cnt - c_cnt_last;
      end
    end
  end

  assign busy      = w_rd | w_wr;
  assign done      = (r_state == S_FIN);
  assign bus_req   = w_rd | w_wr;
  assign ram_en    = (w_rd | w_wr) & bus_gnt;
  assign ram_wr    = w_wr & bus_gnt;
  assign ram_be    = 1'b0;
  assign ram_addr  = w_rd ? r_src : (w_wr ? r_dst : '0);
  assign ram_wdata = w_wr ? (r_mode ? r_fill : r_buf) : '0;

endmodule

`default_nettype wire

// File: tb/tb_ram_copy_dma.sv
// ============================================================================
// Module      : tb_ram_copy_dma
// Description : Directed self-checking bench for ram_copy_dma with a BRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_copy_dma;

  localparam int AW = 17;
  localparam int CW = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          mode;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [CW-1:0] count;
  logic [31:0]   fill_data;
  logic          abort;
  logic          busy;
  logic          done;
  logic          bus_req;
  logic          bus_gnt;
  logic          ram_en;
  logic          ram_wr;
  logic          ram_be;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  logic [31:0] mem [0:32767];
  int n_vec;
  int n_err;
  int en_cnt;
  int wr_cnt;
  int done_cnt;

  ram_copy_dma #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .count(count),
    .fill_data(fill_data), .abort(abort), .busy(busy), .done(done),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .ram_en(ram_en), .ram_wr(ram_wr),
    .ram_be(ram_be), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM clocked on the falling edge; also tallies strobes and done pulses
  always @(negedge clk) begin
    if (ram_en) begin
      en_cnt = en_cnt + 1;
      if (ram_wr) begin
        wr_cnt = wr_cnt + 1;
        mem[ram_addr[AW-1:2]] = ram_wdata;
      end else begin
        ram_rdata = mem[ram_addr[AW-1:2]];
      end
    end
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    assert (obs === exp) else begin
      n_err = n_err + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                      input logic [CW-1:0] n, input logic [31:0] f);
    mode = m; src_addr = s; dst_addr = d; count = n; fill_data = f;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Returns the cycle index (start-accept posedge opens cycle 1) at which done is seen
  task automatic wait_done(input int cyc0, output int cyc);
    cyc = cyc0;
    while (!done && cyc < 40) begin
      tick();
      cyc = cyc + 1;
    end
  endtask

  int cyc;
  int e0;
  int w0;
  int d0;

  initial begin
    n_vec = 0; n_err = 0; en_cnt = 0; wr_cnt = 0; done_cnt = 0;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0; bus_gnt = 1'b1;
    src_addr = '0; dst_addr = '0; count = '0; fill_data = '0; ram_rdata = '0;
    for (int i = 0; i < 32768; i++) mem[i] = 32'hC0DE0000 | i;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_req", {31'd0, bus_req}, 32'd0);
    chk("rst_en", {31'd0, ram_en}, 32'd0);
    chk("rst_wr", {31'd0, ram_wr}, 32'd0);
    chk("rst_be", {31'd0, ram_be}, 32'd0);
    chk("rst_addr", {15'd0, ram_addr}, 32'd0);
    chk("rst_wdata", ram_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: copy three words 0x100 -> 0x200
    mem[32'h40] = 32'hAAAA0001; mem[32'h41] = 32'hBBBB0002; mem[32'h42] = 32'hCCCC0003;
    e0 = en_cnt; d0 = done_cnt;
    kick(1'b0, 17'h100, 17'h200, 16'd3, 32'h0);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_rd_addr", {15'd0, ram_addr}, 32'h100);
    chk("t1_rd_en", {30'd0, ram_en, ram_wr}, 32'b10);
    tick();
    chk("t1_wr_addr", {15'd0, ram_addr}, 32'h200);
    chk("t1_wr_data", ram_wdata, 32'hAAAA0001);
    wait_done(2, cyc);
    chk("t1_done_cyc", cyc, 32'd7);
    chk("t1_busy_fin", {31'd0, busy}, 32'd0);
    tick();
    chk("t1_done_pulse", {31'd0, done}, 32'd0);
    chk("t1_busy_after", {31'd0, busy}, 32'd0);
    chk("t1_accesses", en_cnt - e0, 32'd6);
    chk("t1_done_cnt", done_cnt - d0, 32'd1);
    chk("t1_m0", mem[32'h80], 32'hAAAA0001);
    chk("t1_m1", mem[32'h81], 32'hBBBB0002);
    chk("t1_m2", mem[32'h82], 32'hCCCC0003);

    // 2: fill four words at 0x40
    mem[32'h14] = 32'h55555555;
    w0 = wr_cnt; e0 = en_cnt;
    kick(1'b1, 17'h0, 17'h40, 16'd4, 32'hDEADBEEF);
    chk("t2_wdata", ram_wdata, 32'hDEADBEEF);
    chk("t2_wr_addr", {15'd0, ram_addr}, 32'h40);
    chk("t2_be", {31'd0, ram_be}, 32'd0);
    wait_done(1, cyc);
    chk("t2_done_cyc", cyc, 32'd5);
    tick();
    chk("t2_writes", wr_cnt - w0, 32'd4);
    chk("t2_accesses", en_cnt - e0, 32'd4);
    for (int i = 0; i < 4; i++) chk("t2_fill", mem[32'h10 + i], 32'hDEADBEEF);
    chk("t2_untouched", mem[32'h14], 32'h55555555);

    // 3: zero count
    e0 = en_cnt;
    kick(1'b0, 17'h100, 17'h200, 16'd0, 32'h0);
    chk("t3_done", {31'd0, done}, 32'd1);
    chk("t3_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("t3_done_off", {31'd0, done}, 32'd0);
    chk("t3_busy2", {31'd0, busy}, 32'd0);
    tick();
    chk("t3_no_en", en_cnt - e0, 32'd0);

    // 4: grant withdrawn for three cycles during the first write
    mem[32'hC0] = 32'h11112222; mem[32'hC1] = 32'h33334444;
    kick(1'b0, 17'h300, 17'h400, 16'd2, 32'h0);
    tick();
    chk("t4_wr_addr", {15'd0, ram_addr}, 32'h400);
    bus_gnt = 1'b0;
    #1;
    chk("t4_stall_en", {31'd0, ram_en}, 32'd0);
    chk("t4_stall_req", {31'd0, bus_req}, 32'd1);
    tick();
    chk("t4_hold_addr", {15'd0, ram_addr}, 32'h400);
    chk("t4_hold_data", ram_wdata, 32'h11112222);
    tick();
    chk("t4_hold_en", {31'd0, ram_en}, 32'd0);
    tick();
    bus_gnt = 1'b1;
    #1;
    chk("t4_resume_en", {30'd0, ram_en, ram_wr}, 32'b11);
    chk("t4_resume_addr", {15'd0, ram_addr}, 32'h400);
    chk("t4_resume_data", ram_wdata, 32'h11112222);
    wait_done(5, cyc);
    chk("t4_done_cyc", cyc, 32'd8);
    tick();
    chk("t4_m0", mem[32'h100], 32'h11112222);
    chk("t4_m1", mem[32'h101], 32'h33334444);

    // 5: destination wraps past the top of the address space
    mem[0] = 32'h0BADF00D;
    kick(1'b1, 17'h0, 17'h1FFFC, 16'd2, 32'h12345678);
    chk("t5_addr_top", {15'd0, ram_addr}, 32'h1FFFC);
    tick();
    chk("t5_addr_wrap", {15'd0, ram_addr}, 32'h0);
    wait_done(2, cyc);
    chk("t5_done_cyc", cyc, 32'd3);
    tick();
    chk("t5_m_top", mem[32'h7FFF], 32'h12345678);
    chk("t5_m_zero", mem[0], 32'h12345678);

    // 6: abort during the third write of an eight-word copy
    for (int i = 0; i < 8; i++) begin
      mem[32'h140 + i] = 32'h5A000000 + i;
      mem[32'h180 + i] = 32'hFFFF0000 + i;
    end
    d0 = done_cnt;
    kick(1'b0, 17'h500, 17'h600, 16'd8, 32'h0);
    for (int i = 0; i < 5; i++) tick();
    chk("t6_third_wr", {15'd0, ram_addr}, 32'h608);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_done", {31'd0, done}, 32'd0);
    tick();
    tick();
    chk("t6_no_done", done_cnt - d0, 32'd0);
    chk("t6_m0", mem[32'h180], 32'h5A000000);
    chk("t6_m2", mem[32'h182], 32'h5A000002);
    chk("t6_m3", mem[32'h183], 32'hFFFF0003);
    chk("t6_m7", mem[32'h187], 32'hFFFF0007);

    // Asynchronous reset mid-transfer
    kick(1'b0, 17'h500, 17'h700, 16'd4, 32'h0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6r_busy", {31'd0, busy}, 32'd0);
    chk("t6r_en", {31'd0, ram_en}, 32'd0);
    chk("t6r_req", {31'd0, bus_req}, 32'd0);
    chk("t6r_addr", {15'd0, ram_addr}, 32'd0);
    chk("t6r_wdata", ram_wdata, 32'd0);
    d0 = done_cnt;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("t6r_no_done", done_cnt - d0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
